// File: rtl/sdram_sched_pkg.sv
// sdram_sched_pkg: shared types and default geometry for the SDRAM request scheduler.
package sdram_sched_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, BUSY} state_e;
    localparam int DEF_NUM_REQ      = 4;
    localparam int DEF_ADDR_W       = 25;
    localparam int DEF_LEN_W        = 6;
    localparam int DEF_STARVE_LIMIT = 16;
    localparam int DEF_ID_W         = $clog2(DEF_NUM_REQ);
    localparam int DEF_BEAT_W       = DEF_LEN_W;
    typedef struct packed {
        logic                  write;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_LEN_W-1:0]  len;
        logic [DEF_ID_W-1:0]   id;
    } cmd_t;
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/sdram_req_scheduler_rr_pick.sv
// rr_pick: combinational round-robin picker; first set request at or after the pointer wins, wrapping.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        // Scan from the far end so the candidate closest to the pointer is written last.
        for (int k = N - 1; k >= 0; k--) begin
            if (req_i[(int'(ptr_i) + k) % N]) begin
                gnt_o = '0;
                gnt_o[(int'(ptr_i) + k) % N] = 1'b1;
                idx_o = IW'((int'(ptr_i) + k) % N);
            end
        end
    end
    assign any_o = |req_i;
endmodule

// File: rtl/sdram_req_scheduler.sv
// sdram_req_scheduler: round-robin read-over-write burst scheduler feeding one SDRAM controller.
// Define SDRAM_SCHED_STARVE_EN to let requesters waiting STARVE_LIMIT cycles override class priority.
module sdram_req_scheduler
    import sdram_sched_pkg::*;
#(
    parameter int NUM_REQ      = DEF_NUM_REQ,
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int LEN_W        = DEF_LEN_W,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
    parameter int ID_W         = id_width(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ-1:0]             req_write,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ-1:0][LEN_W-1:0]  req_len,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [NUM_REQ-1:0]             req_done,
    output logic                           cmd_valid,
    input  logic                           cmd_ready,
    output logic                           cmd_write,
    output logic [ADDR_W-1:0]              cmd_addr,
    output logic [LEN_W-1:0]               cmd_len,
    output logic [ID_W-1:0]                cmd_id,
    input  logic                           beat_valid,
    output logic                           protocol_err
);
    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
        logic [ID_W-1:0]   id;
    } sched_cmd_t;

    state_e             state_q;
    sched_cmd_t         cmd_q;
    logic [LEN_W-1:0]   beat_q;
    logic [ID_W-1:0]    ptr_q;
    logic               err_q;
    logic [NUM_REQ-1:0] rd_gnt, wr_gnt, win_oh;
    logic [ID_W-1:0]    rd_idx, wr_idx, win_idx;
    logic               rd_any, wr_any;
    logic               last_beat;

    rr_pick #(.N(NUM_REQ), .IW(ID_W)) u_rd_pick (
        .req_i(req_valid & ~req_write), .ptr_i(ptr_q),
        .gnt_o(rd_gnt), .idx_o(rd_idx), .any_o(rd_any)
    );
    rr_pick #(.N(NUM_REQ), .IW(ID_W)) u_wr_pick (
        .req_i(req_valid & req_write), .ptr_i(ptr_q),
        .gnt_o(wr_gnt), .idx_o(wr_idx), .any_o(wr_any)
    );

`ifdef SDRAM_SCHED_STARVE_EN
    localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);
    logic [NUM_REQ-1:0][WAIT_W-1:0] wait_q, wait_d;
    logic [NUM_REQ-1:0]             starve, st_gnt;
    logic [ID_W-1:0]                st_idx;
    logic                           st_any;

    // A requester one short of the limit reaches it on this edge, so it already counts as starved.
    always_comb begin
        starve = '0;
        wait_d = wait_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            starve[i] = req_valid[i] && wait_q[i] >= WAIT_W'(STARVE_LIMIT - 1);
            wait_d[i] = (!req_valid[i] || (win_oh[i] && state_q == IDLE) ||
                         (state_q != IDLE && cmd_q.id == ID_W'(i))) ? '0 :
                        (wait_q[i] == WAIT_W'(STARVE_LIMIT)) ? wait_q[i] : wait_q[i] + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) wait_q <= '0;
        else     wait_q <= wait_d;
    end

    rr_pick #(.N(NUM_REQ), .IW(ID_W)) u_st_pick (
        .req_i(starve), .ptr_i(ptr_q),
        .gnt_o(st_gnt), .idx_o(st_idx), .any_o(st_any)
    );

    assign win_oh  = st_any ? st_gnt : rd_any ? rd_gnt : wr_gnt;
    assign win_idx = st_any ? st_idx : rd_any ? rd_idx : wr_idx;
`else
    assign win_oh  = rd_any ? rd_gnt : wr_gnt;
    assign win_idx = rd_any ? rd_idx : wr_idx;
`endif

    assign last_beat = state_q == BUSY && beat_valid && beat_q == cmd_q.len;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cmd_q   <= '0;
            beat_q  <= '0;
            ptr_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            if (beat_valid && state_q != BUSY) err_q <= 1'b1;
            case (state_q)
                IDLE: if (rd_any || wr_any) begin
                    cmd_q   <= '{write: |(win_oh & req_write), addr: req_addr[win_idx],
                                 len: req_len[win_idx], id: win_idx};
                    ptr_q   <= (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
                    state_q <= ISSUE;
                end
                ISSUE: if (cmd_ready) begin
                    beat_q  <= '0;
                    state_q <= BUSY;
                end
                BUSY: if (last_beat) state_q <= IDLE;
                      else if (beat_valid) beat_q <= beat_q + 1'b1;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_valid    = state_q == ISSUE;
    assign cmd_write    = cmd_q.write;
    assign cmd_addr     = cmd_q.addr;
    assign cmd_len      = cmd_q.len;
    assign cmd_id       = cmd_q.id;
    assign req_ready    = (state_q == ISSUE && cmd_ready) ? NUM_REQ'(1) << cmd_q.id : '0;
    assign req_done     = last_beat ? NUM_REQ'(1) << cmd_q.id : '0;
    assign protocol_err = err_q;
endmodule

// File: doc/sdram_req_scheduler.md
# sdram_req_scheduler

Multi-requester scheduler between the cache/scratchpad request ports and the single SDRAM controller command port. Selects one read or write burst at a time, with round-robin fairness, read-over-write preference and an optional write-starvation override. Latches the winning command, hands it to the controller, counts data beats to burst completion, then signals done to the owning requester.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (≥2)
- ADDR_W, 25, word address width
- LEN_W, 6, burst length field width; encodes beats−1
- STARVE_LIMIT, 16, wait cycles before a requester is starved (≥1)

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- req_valid  in  [NUM_REQ]  request pending; held until req_ready
- req_write  in  [NUM_REQ]  1 = write burst, 0 = read burst
- req_addr  in  [NUM_REQ][ADDR_W]  start address
- req_len  in  [NUM_REQ][LEN_W]  beats−1
- req_ready  out  [NUM_REQ]  one-cycle pulse: command accepted by controller
- req_done  out  [NUM_REQ]  one-cycle pulse: last beat of that requester's burst transferred
- cmd_valid  out  1  command presented to controller
- cmd_ready  in  1  controller accepts command
- cmd_write, cmd_addr, cmd_len  out  1 / ADDR_W / LEN_W  latched command fields
- cmd_id  out  clog2(NUM_REQ)  owning requester
- beat_valid  in  1  controller transferred one data word of the active burst
- protocol_err  out  1  sticky: beat_valid seen outside BUSY

## Operation
- States: IDLE, ISSUE, BUSY. Reset → IDLE; all outputs 0, rr pointer 0, wait counters 0, beat counter 0.
- IDLE: if any req_valid, select winner combinationally, latch cmd fields and cmd_id, set rr pointer = (winner+1) mod NUM_REQ, clear winner's wait counter → ISSUE. Else stay.
- Selection priority: starved class > read class > write class; within a class, first set requester at or after rr pointer, wrapping.
- ISSUE: cmd_valid=1, fields stable. On cmd_ready: req_ready[cmd_id]=1 that cycle, beat counter=0 → BUSY.
- BUSY: each beat_valid increments beat counter. Beat with counter == cmd_len: req_done[cmd_id]=1 same cycle, → IDLE.
- cmd_len=0 is a 1-beat burst; all-ones is 2^LEN_W beats. Counter is LEN_W bits, never wraps.
- Wait counters: per requester, increment each cycle req_valid=1 and not selected/owning; saturate at STARVE_LIMIT; clear on selection or req_valid=0. Starved = counter == STARVE_LIMIT.
- Requester dropping req_valid during ISSUE/BUSY has no effect; latched command completes.
- beat_valid in IDLE or ISSUE: ignored, protocol_err set until reset.
- Reset mid-burst: immediate return to IDLE, no req_done; controller reset together.

## Timing
- Request visible in IDLE → cmd_valid next cycle (1-cycle latency).
- cmd_valid&cmd_ready cycle → req_ready pulse same cycle.
- Last beat cycle → req_done same cycle; next selection evaluated in following IDLE cycle (one idle cycle between bursts minimum).
- Starvation counts the IDLE-cycle selection edge; requester reaching STARVE_LIMIT in the cycle of a selection is considered starved in that selection.

## Configuration
- SDRAM_SCHED_STARVE_EN defined: starved class active as above.
- Undefined: wait counters absent; priority is read class > write class only, round-robin within class. Writes can starve under continuous reads.

## Structure
- Shared package sdram_sched_pkg: state enum, beat-count and id width localparams, cmd struct {write, addr, len, id}.
- Sub-module rr_pick: combinational round-robin picker (request mask, pointer → one-hot grant, index, any); instantiated once per priority class.

## Test plan
- Single read, req 2, addr 0x100, len 7 → cmd_valid 1 cycle later, cmd_id 2; 8 beats → req_done[2] on 8th beat.
- Reads on req 0,1,3 held continuously, len 0 → grant order 0,1,3,0,1,3 (rr wrap).
- Write req 1 plus read req 2 simultaneously → read 2 first, then write 1.
- STARVE_EN: write req 0 held while reads 1–3 continuously re-request, len 3 → write 0 granted once wait counter hits 16; without macro never granted while reads present.
- beat_valid pulsed in IDLE → protocol_err=1, stays until rst; no req_done.
- rst asserted mid-BUSY at beat 3 of len 15 → all outputs 0 immediately, state IDLE, pending req re-granted after release.
